// File: rtl/leakage_sweep_seq_pkg.sv
// rtl/leakage_sweep_seq_pkg.sv - shared types and helpers for the leakage sweep sequencer
//
// Contents:
//   state_t   - sequencer FSM states
//   result_t  - one leakage result record (code, value, timeout), sized for the widest legal build
//   sat_neg   - two's complement negate of a w-bit signed value, saturating the most-negative input
package leakage_pkg;

  localparam int MAX_W    = 64;
  localparam int MAX_N_IN = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_TRIG,
    ST_WAIT_S,
    ST_EMIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [MAX_N_IN-1:0]     code;
    logic signed [MAX_W-1:0] value;
    logic                    timeout;
  } result_t;

  // x holds a sign-extended w-bit value; negating -2^(w-1) would not fit back
  // into w bits, so it clamps to the largest positive w-bit value instead.
  function automatic logic signed [MAX_W-1:0] sat_neg(input logic signed [MAX_W-1:0] x,
                                                      input int w);
    logic signed [MAX_W-1:0] lim;
    lim = 64'sd1 <<< (w - 1);
    if (x == -lim) begin
      return lim - 64'sd1;
    end
    return -x;
  endfunction

endpackage

// File: rtl/leakage_sweep_seq_if.sv
// rtl/leakage_sweep_seq_if.sv - measurement-trigger and result-stream bundle of the sweep sequencer
//
// Signals:
//   start_measure  sequencer -> front-end, toggles once per requested sample
//   sample_valid   front-end -> sequencer, one-cycle strobe
//   sample         front-end -> sequencer, signed integrated supply current
//   res_valid      sequencer -> writer, result available
//   res_ready      writer -> sequencer, result accepted when both high
//   res_code       sequencer -> writer, input state of the result
//   res_value      sequencer -> writer, signed leakage (negated average, saturated)
//   res_timeout    sequencer -> writer, at least one sample of this result timed out
// Modports: master = sequencer side, slave = front-end/writer side.
interface leakage_sweep_seq_if #(
  parameter int N_IN     = 2,
  parameter int SAMPLE_W = 24
) ();

  logic                       start_measure;
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] sample;
  logic                       res_valid;
  logic                       res_ready;
  logic [N_IN-1:0]            res_code;
  logic signed [SAMPLE_W-1:0] res_value;
  logic                       res_timeout;

  modport master (
    output start_measure,
    input  sample_valid,
    input  sample,
    output res_valid,
    input  res_ready,
    output res_code,
    output res_value,
    output res_timeout
  );

  modport slave (
    input  start_measure,
    output sample_valid,
    output sample,
    input  res_valid,
    output res_ready,
    input  res_code,
    input  res_value,
    input  res_timeout
  );

endinterface

// File: rtl/leakage_avg_acc.sv
// rtl/leakage_avg_acc.sv - sample accumulator, averager and slot counter for one input state
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         clears accumulator and slot counter (start of a state)
//   acc_en      adds acc_in and advances the slot counter
//   acc_in      signed sample to add (0 for a timed-out slot)
//   last_slot   the slot being filled is the final one of this state
//   res_value   -(accumulator >>> AVG_LOG2), saturated to SAMPLE_W bits
module leakage_avg_acc
  import leakage_pkg::*;
#(
  parameter int SAMPLE_W = 24,
  parameter int AVG_LOG2 = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       acc_en,
  input  logic signed [SAMPLE_W-1:0] acc_in,
  output logic                       last_slot,
  output logic signed [SAMPLE_W-1:0] res_value
);

  localparam int ACC_W = SAMPLE_W + AVG_LOG2;
  // One extra bit so the counter can hold 2^AVG_LOG2 after the last slot,
  // and stays non-zero width when AVG_LOG2 is 0.
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic signed [ACC_W-1:0]    acc_q;
  logic [CNT_W-1:0]           cnt_q;
  logic signed [SAMPLE_W-1:0] avg;
  logic signed [MAX_W-1:0]    neg_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (acc_en) begin
      acc_q <= acc_q + ACC_W'(acc_in);
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign last_slot = (cnt_q == LAST);

  // Arithmetic shift floors toward -inf; the quotient always fits in SAMPLE_W.
  assign avg       = SAMPLE_W'(acc_q >>> AVG_LOG2);
  assign neg_w     = sat_neg(64'(avg), SAMPLE_W);
  assign res_value = SAMPLE_W'(neg_w);

endmodule

// File: rtl/leakage_sweep_seq.sv
// rtl/leakage_sweep_seq.sv - sweeps a cell input vector and streams averaged leakage per state
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       one-cycle pulse, starts a sweep when idle
//   din_vec     cell input vector (bit 0 = A1)
//   busy        high from accepted start until DONE
//   done        one-cycle pulse after the last result is accepted
//   bus         measurement trigger/sample and result stream (master side)
module leakage_sweep_seq
  import leakage_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int SETTLE_CYC = 700,
  parameter int MEAS_CYC   = 700,
  parameter int SAMPLE_W   = 24,
  parameter int AVG_LOG2   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [N_IN-1:0]       din_vec,
  output logic                  busy,
  output logic                  done,
  leakage_sweep_seq_if.master   bus
);

  localparam int CNT_MAX = (SETTLE_CYC > MEAS_CYC) ? SETTLE_CYC : MEAS_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] MEAS_LOAD   = CNT_W'(MEAS_CYC - 1);
  localparam logic [N_IN-1:0]  LAST_CODE   = {N_IN{1'b1}};

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [N_IN-1:0]   code_q;
  logic              sm_q;
  logic              res_valid_q;
  logic              to_q;
  logic              busy_q;
  logic              done_q;

  logic                       sample_taken;
  logic                       slot_timeout;
  logic                       acc_en;
  logic                       acc_clr;
  logic                       accept;
  logic                       last_slot;
  logic signed [SAMPLE_W-1:0] acc_in;
  logic signed [SAMPLE_W-1:0] avg_neg;

  // A strobe in the expiry cycle counts as a sample, not a timeout.
  assign sample_taken = (state_q == ST_WAIT_S) && bus.sample_valid;
  assign slot_timeout = (state_q == ST_WAIT_S) && !bus.sample_valid && (cnt_q == '0);
  assign acc_en       = sample_taken || slot_timeout;
  assign acc_in       = sample_taken ? bus.sample : '0;
  assign accept       = (state_q == ST_EMIT) && bus.res_ready;
  assign acc_clr      = ((state_q == ST_IDLE) && start) || accept;

  leakage_avg_acc #(
    .SAMPLE_W (SAMPLE_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (acc_clr),
    .acc_en    (acc_en),
    .acc_in    (acc_in),
    .last_slot (last_slot),
    .res_value (avg_neg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      code_q      <= '0;
      sm_q        <= 1'b0;
      res_valid_q <= 1'b0;
      to_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            code_q  <= '0;
            to_q    <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= SETTLE_LOAD;
            state_q <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= ST_TRIG;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_TRIG: begin
          sm_q    <= ~sm_q;
          cnt_q   <= MEAS_LOAD;
          state_q <= ST_WAIT_S;
        end

        ST_WAIT_S: begin
          if (acc_en) begin
            if (slot_timeout) begin
              to_q <= 1'b1;
            end
            // last_slot reflects the count before this slot is added.
            if (last_slot) begin
              res_valid_q <= 1'b1;
              state_q     <= ST_EMIT;
            end else begin
              state_q <= ST_TRIG;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_EMIT: begin
          if (accept) begin
            res_valid_q <= 1'b0;
            to_q        <= 1'b0;
            if (code_q == LAST_CODE) begin
              code_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              code_q  <= code_q + N_IN'(1);
              cnt_q   <= SETTLE_LOAD;
              state_q <= ST_SETTLE;
            end
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign din_vec           = code_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign bus.start_measure = sm_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_code      = code_q;
  assign bus.res_value     = avg_neg;
  assign bus.res_timeout   = to_q;

endmodule

// File: tb/tb_leakage_sweep_seq.sv
// tb/tb_leakage_sweep_seq.sv - directed self-checking bench for leakage_sweep_seq
module tb_leakage_sweep_seq;
  import leakage_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] din_vec;
  logic       busy;
  logic       done;

  leakage_sweep_seq_if #(.N_IN(2), .SAMPLE_W(24)) bus ();

  leakage_sweep_seq #(
    .N_IN       (2),
    .SETTLE_CYC (10),
    .MEAS_CYC   (20),
    .SAMPLE_W   (24),
    .AVG_LOG2   (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .din_vec (din_vec),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  int      total;
  int      bad;
  int      cyc;
  int      toggles;
  int      done_cnt;
  int      slot_base;
  int      start_cyc;
  int      samp_tab [16];
  bit      drop_tab [16];
  result_t got [4];
  int      got_cyc [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // Front-end model: on each start_measure toggle, answer in the 3rd wait
  // cycle with samp_tab[slot], or stay silent when drop_tab[slot] is set.
  initial begin : responder
    logic prev;
    int   idx;
    prev             = 1'b0;
    toggles          = 0;
    bus.sample_valid = 1'b0;
    bus.sample       = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n !== 1'b1) begin
        prev = 1'b0;
      end else if (bus.start_measure !== prev) begin
        prev = bus.start_measure;
        idx  = toggles - slot_base;
        toggles++;
        if (idx >= 0 && idx < 16 && !drop_tab[idx]) begin
          repeat (2) @(posedge clk);
          #1;
          bus.sample       = 24'(samp_tab[idx]);
          bus.sample_valid = 1'b1;
          @(posedge clk); #1;
          bus.sample_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic fill(input int v);
    for (int i = 0; i < 16; i++) begin
      samp_tab[i] = v;
      drop_tab[i] = 1'b0;
    end
  endtask

  // Runs one full sweep; hold > 0 keeps res_ready low that many cycles on the first result.
  task automatic run_sweep(input int hold);
    int         t;
    logic [1:0] hv_code;
    logic [23:0] hv_val;
    logic       hv_to;
    logic [1:0] hv_din;
    int         hv_tog;
    bit         moved;
    slot_base = toggles;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    start_cyc = cyc;
    total++;
    if (busy !== 1'b1) begin
      $display("FAIL busy_after_start: got %b want 1", busy);
      bad++;
    end
    for (int r = 0; r < 4; r++) begin
      t = 0;
      while (bus.res_valid !== 1'b1 && t < 600) begin
        @(posedge clk); #1;
        t++;
      end
      total++;
      if (t >= 600) begin
        $display("FAIL res_valid_wait r=%0d: waited %0d cycles, want < 600", r, t);
        bad++;
        return;
      end
      got[r].code    = 4'(bus.res_code);
      got[r].value   = 64'(bus.res_value);
      got[r].timeout = bus.res_timeout;
      got_cyc[r]     = cyc;
      total++;
      if (din_vec !== 2'(r)) begin
        $display("FAIL din_vec_in_emit r=%0d: got %0d want %0d", r, din_vec, r);
        bad++;
      end
      if (hold > 0 && r == 0) begin
        hv_code = bus.res_code;
        hv_val  = bus.res_value;
        hv_to   = bus.res_timeout;
        hv_din  = din_vec;
        hv_tog  = toggles;
        moved   = 1'b0;
        for (int h = 0; h < hold; h++) begin
          start = (h == 10);
          @(posedge clk); #1;
          if (bus.res_valid !== 1'b1 || bus.res_code !== hv_code || bus.res_value !== hv_val ||
              bus.res_timeout !== hv_to || din_vec !== hv_din)
            moved = 1'b1;
        end
        start = 1'b0;
        total++;
        if (moved) begin
          $display("FAIL bp_stable: result or din_vec changed while res_ready low (got code %0d val %0d)", bus.res_code, bus.res_value);
          bad++;
        end
        total++;
        if (toggles !== hv_tog) begin
          $display("FAIL bp_no_trigger: got %0d toggles want %0d", toggles, hv_tog);
          bad++;
        end
        bus.res_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (hold > 0 && r == 0) begin
        total++;
        if (bus.res_valid !== 1'b0 || din_vec !== 2'd1) begin
          $display("FAIL bp_accept: got res_valid=%b din_vec=%0d want 0 and 1", bus.res_valid, din_vec);
          bad++;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    start         = 1'b0;
    bus.res_ready = 1'b0;
    slot_base     = 0;
    fill(-400);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (din_vec !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL reset_ctrl: got din=%0d busy=%b done=%b want 0 0 0", din_vec, busy, done);
      bad++;
    end
    total++;
    if (bus.start_measure !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_timeout !== 1'b0) begin
      $display("FAIL reset_flags: got sm=%b rv=%b to=%b want 0 0 0", bus.start_measure, bus.res_valid, bus.res_timeout);
      bad++;
    end
    total++;
    if (bus.res_code !== 2'd0 || bus.res_value !== 24'd0) begin
      $display("FAIL reset_result: got code=%0d val=%0d want 0 0", bus.res_code, bus.res_value);
      bad++;
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || bus.start_measure !== 1'b0) begin
      $display("FAIL idle_after_reset: got busy=%b sm=%b want 0 0", busy, bus.start_measure);
      bad++;
    end
  endtask

  task automatic test_basic;
    int dc0;
    fill(-400);
    bus.res_ready = 1'b1;
    dc0 = done_cnt;
    run_sweep(0);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL basic_done_pulse: got done=%b busy=%b want 1 0", done, busy);
      bad++;
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (done_cnt - dc0 !== 1) begin
      $display("FAIL basic_done_count: got %0d want 1", done_cnt - dc0);
      bad++;
    end
    total++;
    if (toggles - slot_base !== 16) begin
      $display("FAIL basic_toggles: got %0d want 16", toggles - slot_base);
      bad++;
    end
    total++;
    if (got_cyc[0] - start_cyc !== 26) begin
      $display("FAIL basic_first_latency: got %0d want 26", got_cyc[0] - start_cyc);
      bad++;
    end
    for (int r = 0; r < 4; r++) begin
      total++;
      if (got[r].code !== 4'(r) || got[r].value !== 64'sd400 || got[r].timeout !== 1'b0) begin
        $display("FAIL basic_result r=%0d: got code=%0d val=%0d to=%b want %0d 400 0",
                 r, got[r].code, got[r].value, got[r].timeout, r);
        bad++;
      end
      if (r > 0) begin
        total++;
        if (got_cyc[r] - got_cyc[r-1] !== 27) begin
          $display("FAIL basic_interval r=%0d: got %0d want 27", r, got_cyc[r] - got_cyc[r-1]);
          bad++;
        end
      end
    end
  endtask

  task automatic test_floor;
    fill(-400);
    samp_tab[0] = -3;
    samp_tab[1] = -4;
    samp_tab[2] = -4;
    samp_tab[3] = -4;
    run_sweep(0);
    total++;
    if (got[0].value !== 64'sd4) begin
      $display("FAIL floor_avg: got %0d want 4", got[0].value);
      bad++;
    end
    total++;
    if (got[1].value !== 64'sd400) begin
      $display("FAIL floor_next_clean: got %0d want 400", got[1].value);
      bad++;
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_saturation;
    fill(-8388608);
    run_sweep(0);
    total++;
    if (got[0].value !== 64'sd8388607) begin
      $display("FAIL sat_code0: got %0d want 8388607", got[0].value);
      bad++;
    end
    total++;
    if (got[3].value !== 64'sd8388607) begin
      $display("FAIL sat_code3: got %0d want 8388607", got[3].value);
      bad++;
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_timeout;
    fill(-400);
    samp_tab[0] = -300;
    drop_tab[1] = 1'b1;
    samp_tab[2] = -300;
    samp_tab[3] = -300;
    run_sweep(0);
    total++;
    if (got[0].value !== 64'sd225 || got[0].timeout !== 1'b1) begin
      $display("FAIL timeout_result: got val=%0d to=%b want 225 1", got[0].value, got[0].timeout);
      bad++;
    end
    total++;
    if (got_cyc[0] - start_cyc !== 43) begin
      $display("FAIL timeout_latency: got %0d want 43", got_cyc[0] - start_cyc);
      bad++;
    end
    total++;
    if (got[1].value !== 64'sd400 || got[1].timeout !== 1'b0) begin
      $display("FAIL timeout_flag_cleared: got val=%0d to=%b want 400 0", got[1].value, got[1].timeout);
      bad++;
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_backpressure;
    fill(-400);
    bus.res_ready = 1'b0;
    run_sweep(50);
    total++;
    if (got[0].value !== 64'sd400 || got[3].code !== 4'd3) begin
      $display("FAIL bp_results: got val0=%0d code3=%0d want 400 3", got[0].value, got[3].code);
      bad++;
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    int t;
    fill(-400);
    bus.res_ready = 1'b1;
    slot_base = toggles;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (toggles - slot_base < 9 && t < 600) begin
      @(posedge clk); #1;
      t++;
    end
    total++;
    if (t >= 600) begin
      $display("FAIL rstmid_reach_code2: waited %0d cycles, want < 600", t);
      bad++;
    end
    total++;
    if (din_vec !== 2'd2 || bus.start_measure !== 1'b1) begin
      $display("FAIL rstmid_pre: got din=%0d sm=%b want 2 1", din_vec, bus.start_measure);
      bad++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (din_vec !== 2'd0 || busy !== 1'b0 || bus.start_measure !== 1'b0 || bus.res_valid !== 1'b0) begin
      $display("FAIL rstmid_async: got din=%0d busy=%b sm=%b rv=%b want all 0",
               din_vec, busy, bus.start_measure, bus.res_valid);
      bad++;
    end
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    run_sweep(0);
    total++;
    if (got[0].code !== 4'd0 || got[0].value !== 64'sd400 || got_cyc[0] - start_cyc !== 26) begin
      $display("FAIL rstmid_restart: got code=%0d val=%0d lat=%0d want 0 400 26",
               got[0].code, got[0].value, got_cyc[0] - start_cyc);
      bad++;
    end
    total++;
    if (got[3].code !== 4'd3) begin
      $display("FAIL rstmid_last_code: got %0d want 3", got[3].code);
      bad++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_basic;
    test_floor;
    test_saturation;
    test_timeout;
    test_backpressure;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
